// File: rtl/sine_dds.sv
// Phase-accumulator sine DDS with a pipelined, symmetry-folded quarter-wave
// table; feeds the PWM duty-compare path with two's-complement samples.
module sine_dds #(
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 8,
  parameter int AMP_W   = 9
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               SYNC,
  input  logic [PHASE_W-1:0] FREQ_WORD,
  input  logic [PHASE_W-1:0] PHASE_OFS,
  output logic [AMP_W-1:0]   SINE_OUT,
  output logic               VALID_OUT,
  output logic               WRAP
);

  localparam int QTR = 1 << (ADDR_W - 2);
  localparam int LW  = ADDR_W - 2;
  localparam int IW  = ADDR_W - 1;
  localparam int MW  = AMP_W - 1;

  // Quarter-wave magnitude, round-half-up, evaluated at elaboration
  function automatic logic [MW-1:0] tab_val(input int k);
    real pk;
    real x;
    int  v;
    pk = real'((1 << (AMP_W - 1)) - 1);
    x  = pk * $sin(3.14159265358979323846 * real'(k) / real'(2 * QTR));
    v  = $rtoi(x + 0.5);
    return v[MW-1:0];
  endfunction

  logic [MW-1:0] rom [QTR+1];

  for (genvar k = 0; k <= QTR; k++) begin : g_rom
    assign rom[k] = tab_val(k);
  end

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [PHASE_W-1:0] p1_q;
  logic               w1_q, v1_q;
  logic [IW-1:0]      idx2_q, idx_d;
  logic               n2_q, w2_q, v2_q;
  logic [MW-1:0]      mag3_q;
  logic               n3_q, w3_q, v3_q;
  logic [AMP_W-1:0]   out_q, out_d;
  logic               vo_q, wo_q;
  logic               launch;
  logic [ADDR_W-1:0]  theta;
  logic [1:0]         quad;
  logic [LW-1:0]      low;
  logic               unused_lo;

  assign launch = EN & ~SYNC;
  assign theta  = p1_q[PHASE_W-1 -: ADDR_W];
  assign quad   = theta[ADDR_W-1 -: 2];
  assign low    = theta[LW-1:0];

  if (PHASE_W > ADDR_W) begin : g_lo
    assign unused_lo = ^p1_q[PHASE_W-ADDR_W-1:0];
  end else begin : g_nolo
    assign unused_lo = 1'b0;
  end

  always_comb begin
    {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, FREQ_WORD};
    idx_d = quad[0] ? (IW'(QTR) - {1'b0, low}) : {1'b0, low};
    out_d = n3_q ? (AMP_W'(0) - {1'b0, mag3_q}) : {1'b0, mag3_q};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      p1_q    <= '0;
      w1_q    <= 1'b0;
      v1_q    <= 1'b0;
      idx2_q  <= '0;
      n2_q    <= 1'b0;
      w2_q    <= 1'b0;
      v2_q    <= 1'b0;
      mag3_q  <= '0;
      n3_q    <= 1'b0;
      w3_q    <= 1'b0;
      v3_q    <= 1'b0;
      out_q   <= '0;
      vo_q    <= 1'b0;
      wo_q    <= 1'b0;
    end else begin
      if (SYNC) begin
        acc_q   <= '0;
        carry_q <= 1'b0;
      end else if (EN) begin
        acc_q   <= acc_d;
        carry_q <= carry_d;
      end
      v1_q <= launch;
      if (launch) begin
        p1_q <= acc_q + PHASE_OFS;
        w1_q <= carry_q;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        idx2_q <= idx_d;
        n2_q   <= quad[1];
        w2_q   <= w1_q;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        mag3_q <= rom[idx2_q];
        n3_q   <= n2_q;
        w3_q   <= w2_q;
      end
      vo_q <= v3_q;
      wo_q <= v3_q & w3_q;
      if (v3_q) out_q <= out_d;
    end
  end

  assign SINE_OUT  = out_q;
  assign VALID_OUT = vo_q;
  assign WRAP      = wo_q;

endmodule

// File: doc/sine_dds.md
# sine_dds

Parametrised direct-digital-synthesis sine generator: a phase accumulator driving a pipelined quarter-wave sine table with symmetry folding and two's-complement output. Successor to the fixed 8-bit-in / 9-bit-out combinational sine lookup. Adds configurable widths, a free-running accumulator, a phase offset, sync and valid/wrap signalling. Sits between the control/register logic and the PWM modulator; SINE_OUT feeds the PWM duty-compare path.

## Interface
- PHASE_W, 24, accumulator width in bits.
- ADDR_W, 8, table address bits taken from the top of the phase; QTR = 2^(ADDR_W-2). Constraint: 3 <= ADDR_W <= PHASE_W.
- AMP_W, 9, output width in bits, two's complement; PEAK = 2^(AMP_W-1)-1. Constraint: AMP_W >= 2.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  sample strobe; when high, advances the accumulator and launches one sample.
- SYNC  in  1  accumulator clear; takes priority over EN.
- FREQ_WORD  in  PHASE_W  phase increment per EN.
- PHASE_OFS  in  PHASE_W  phase offset added before lookup.
- SINE_OUT  out  AMP_W  sine sample, two's complement.
- VALID_OUT  out  1  one-cycle strobe per completed sample.
- WRAP  out  1  high with VALID_OUT on the sample following an accumulator carry-out.

## Operation
- **Table contents.** T[k] = round(PEAK * sin(pi*k/(2*QTR))) for k = 0..QTR, giving QTR+1 entries. Rounding is half-up. T[QTR] = PEAK and T[0] = 0. The table is built at elaboration; no file dependency.
- **Stage 0 (accumulator ACC).**
  - SYNC=1: ACC <= 0, CARRY <= 0, no sample launched.
  - Else if EN=1: stage 1 captures {ACC + PHASE_OFS (mod 2^PHASE_W), CARRY}. Then ACC <= ACC + FREQ_WORD (mod 2^PHASE_W), and CARRY <= carry-out of that add.
  - Else: ACC and CARRY hold.
- **Stage 1 (fold).**
  - THETA = top ADDR_W bits of the captured phase; Q = THETA[ADDR_W-1:ADDR_W-2]; L = THETA[ADDR_W-3:0].
  - Index IDX = L for Q = 0 or 2; IDX = QTR - L for Q = 1 or 3. IDX is ADDR_W-1 bits wide, range 0..QTR.
  - NEG = Q[1]. Register IDX, NEG, WRAP flag.
- **Stage 2 (table read).** Register MAG = T[IDX], NEG, WRAP flag.
- **Stage 3 (output).** SINE_OUT <= NEG ? (0 - MAG) : MAG, with AMP_W-bit result. -PEAK is always representable, and the negative of 0 is 0.
- **Gating.** v1 <= EN & ~SYNC; v2 <= v1; v3 <= v2. Each stage loads only when its input valid is high; otherwise it holds. VALID_OUT = v3. WRAP is asserted only while VALID_OUT = 1.
- SINE_OUT holds its last value between samples.
- FREQ_WORD = 0 produces a constant output at phase PHASE_OFS.

## Timing
- **Reset.** Asynchronous. While RST is high, immediately and held:
  - ACC = 0, CARRY = 0;
  - all pipeline registers = 0;
  - SINE_OUT = 0, VALID_OUT = 0, WRAP = 0.
- **Latency.** EN sampled high at edge n gives VALID_OUT high during the cycle after edge n+3, carrying that sample. Latency is fixed at 3; throughput is one sample per clock with EN held high.
- **Inputs.** FREQ_WORD and PHASE_OFS are sampled only at edges where EN=1. Changes take effect on the next sample, with no glitch in queued samples.
- **SYNC with EN in the same cycle.** No sample is launched. The next EN sample uses phase 0 + PHASE_OFS.
- **SYNC with samples in flight.** Samples already in stages 1–3 complete normally.
- **RST mid-pipeline.** In-flight samples are discarded, and no VALID_OUT is produced for them.
- **Accumulator wrap.** Silent modulo 2^PHASE_W. The sample launched after the carry reports WRAP=1.
- **Offset wrap.** The PHASE_OFS addition wraps silently and never sets WRAP.

## Test plan
1. **Reset.** Run with EN=1, then assert RST asynchronously between edges -> SINE_OUT, VALID_OUT and WRAP read 0 before the next edge. After RST drops, the first VALID_OUT occurs 3 cycles after the first EN edge.
2. **Full cycle, defaults.** FREQ_WORD=0x010000 (one address per sample), PHASE_OFS=0, EN=1:
   - SINE_OUT = 0, 6, 13, 19, …;
   - THETA 32 -> 180, 64 -> 255, 128 -> 0;
   - THETA 129 -> 0x1FA (-6), 192 -> 0x101 (-255);
   - 256 samples per period, WRAP=1 on every sample with THETA=0 after the first.
3. **Latency and gating.** Single-cycle EN pulses at arbitrary spacing -> exactly one VALID_OUT per pulse, 3 cycles later. SINE_OUT stable between pulses.
4. **Offset.** PHASE_OFS=0x400000, FREQ_WORD=0 -> constant 255. PHASE_OFS=0xC00000 -> constant 0x101.
5. **Sync.** Mid-run, assert SYNC together with EN for 1 cycle, with PHASE_OFS=0 -> that cycle launches no sample. The next sample is 0, followed by 6 with the same FREQ_WORD.
6. **Parameter sweep.** ADDR_W=6, AMP_W=12, PHASE_W=16 -> peak 2047, minimum 0x801. Every output equals a real-arithmetic reference model bit-exactly over two full periods. Q1 mirrors Q0, and Q2/Q3 are the negation of Q0/Q1.
